// File: rtl/instr_loader_pkg.sv
// Shared constants and types for the instruction loader and the instruction memory it feeds.
package instr_loader_pkg;

  localparam int unsigned MEM_DEPTH      = 32;
  localparam logic [31:0] HALT_WORD      = 32'hFFFF_FFFF;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned BYTES_PER_WORD = WORD_W / BYTE_W;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/instr_loader_byte_assembler.sv
// Packs a byte stream into words; word/word_valid are combinational on the final byte of a word.
module instr_loader_byte_assembler
  import instr_loader_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

  logic [WORD_W-1:0] shift_q, shift_d, shifted;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    if (BIG_ENDIAN) begin
      shifted = {shift_q[WORD_W-BYTE_W-1:0], byte_data};
    end else begin
      shifted = {byte_data, shift_q[WORD_W-1:BYTE_W]};
    end
  end

  // Clear wins over a simultaneous byte so a restart drops that byte.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (byte_valid) begin
      shift_d = shifted;
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  assign word       = shifted;
  assign word_valid = byte_valid & ~clear & (cnt_q == LAST_BYTE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Debug front end: loads UART bytes as 32-bit words into instruction memory until halt or full.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned MEM_DEPTH  = instr_loader_pkg::MEM_DEPTH,
  parameter logic [31:0] HALT_WORD  = instr_loader_pkg::HALT_WORD,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       rx_valid,
  input  logic [BYTE_W-1:0]          rx_data,
  output logic                       wr_instruction,
  output logic [WORD_W-1:0]          data_instruction,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       busy,
  output logic                       done,
  output logic                       full_err,
  output logic [$clog2(MEM_DEPTH):0] word_count
);

  localparam int unsigned CNT_W = $clog2(MEM_DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MEM_DEPTH - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  index_q, index_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_err_q, full_err_d;
  logic              wr_q, wr_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              asm_valid;
  logic [WORD_W-1:0] asm_word;
  logic              asm_word_valid;

  // Bytes only count while loading; start drops a coincident byte.
  assign asm_valid = rx_valid & (state_q == StLoad) & ~start;

  instr_loader_byte_assembler #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_byte_assembler (
    .clk        (clk),
    .rst        (rst),
    .clear      (start),
    .byte_valid (asm_valid),
    .byte_data  (rx_data),
    .word       (asm_word),
    .word_valid (asm_word_valid)
  );

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    count_d    = count_q;
    full_err_d = full_err_q;
    wr_d       = 1'b0;
    data_d     = data_q;
    addr_d     = addr_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StLoad;
          index_d    = '0;
          count_d    = '0;
          full_err_d = 1'b0;
        end
      end
      StLoad: begin
        if (start) begin
          index_d    = '0;
          count_d    = '0;
          full_err_d = 1'b0;
        end else begin
          if (asm_word_valid) begin
            wr_d   = 1'b1;
            data_d = asm_word;
            addr_d = ADDR_W'(index_q);
          end
          // Exit decision is taken at the end of the write pulse cycle.
          if (wr_q) begin
            index_d = index_q + CNT_W'(1);
            count_d = count_q + CNT_W'(1);
            if (data_q == HALT_WORD) begin
              state_d    = StDone;
              full_err_d = 1'b0;
            end else if (index_q == LAST_IDX) begin
              state_d    = StDone;
              full_err_d = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      index_q    <= '0;
      count_q    <= '0;
      full_err_q <= 1'b0;
      wr_q       <= 1'b0;
      data_q     <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      count_q    <= count_d;
      full_err_q <= full_err_d;
      wr_q       <= wr_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
    end
  end

  assign wr_instruction   = wr_q;
  assign data_instruction = data_q;
  assign wr_addr          = addr_q;
  assign busy             = (state_q == StLoad);
  assign done             = (state_q == StDone);
  assign full_err         = full_err_q;
  assign word_count       = count_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: big-endian instance for most scenarios, little-endian for byte order.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, rx_valid;
  logic [7:0]  rx_data;
  logic        wr_instruction, busy, done, full_err;
  logic [31:0] data_instruction, wr_addr;
  logic [5:0]  word_count;

  logic        start_le, rx_valid_le;
  logic [7:0]  rx_data_le;
  logic        wr_instruction_le, busy_le, done_le, full_err_le;
  logic [31:0] data_instruction_le, wr_addr_le;
  logic [5:0]  word_count_le;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];
  int          le_writes = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory-side view: capture every write the memory would sample.
  always @(negedge clk) begin
    if (wr_instruction === 1'b1) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(data_instruction);
      wq_cyc.push_back(cyc);
    end
    if (wr_instruction_le === 1'b1) le_writes = le_writes + 1;
  end

  instr_loader #(
    .MEM_DEPTH  (32),
    .HALT_WORD  (32'hFFFF_FFFF),
    .BIG_ENDIAN (1'b1)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .rx_valid         (rx_valid),
    .rx_data          (rx_data),
    .wr_instruction   (wr_instruction),
    .data_instruction (data_instruction),
    .wr_addr          (wr_addr),
    .busy             (busy),
    .done             (done),
    .full_err         (full_err),
    .word_count       (word_count)
  );

  instr_loader #(
    .MEM_DEPTH  (32),
    .HALT_WORD  (32'hFFFF_FFFF),
    .BIG_ENDIAN (1'b0)
  ) dut_le (
    .clk              (clk),
    .rst              (rst),
    .start            (start_le),
    .rx_valid         (rx_valid_le),
    .rx_data          (rx_data_le),
    .wr_instruction   (wr_instruction_le),
    .data_instruction (data_instruction_le),
    .wr_addr          (wr_addr_le),
    .busy             (busy_le),
    .done             (done_le),
    .full_err         (full_err_le),
    .word_count       (word_count_le)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  task automatic test_reset();
    n_checks++; if (wr_instruction !== 1'b0) begin n_fail++; $display("FAIL reset_wr: got %b want 0", wr_instruction); end
    n_checks++; if (data_instruction !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data_instruction); end
    n_checks++; if (wr_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", wr_addr); end
    n_checks++; if ({busy, done, full_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {busy, done, full_err}); end
    n_checks++; if (word_count !== 6'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", word_count); end
  endtask

  task automatic test_basic();
    clear_log();
    pulse_start();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
    send_byte(8'h00); tick();
    send_byte(8'h22);
    send_byte(8'h18); tick();
    send_byte(8'h20);
    n_checks++; if (wr_instruction !== 1'b1) begin n_fail++; $display("FAIL basic_pulse0: got %b want 1", wr_instruction); end
    n_checks++; if (data_instruction !== 32'h0022_1820) begin n_fail++; $display("FAIL basic_data0: got %h want 00221820", data_instruction); end
    tick();
    n_checks++; if (wr_instruction !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width: got %b want 0", wr_instruction); end
    n_checks++; if (data_instruction !== 32'h0022_1820) begin n_fail++; $display("FAIL basic_data_hold: got %h want 00221820", data_instruction); end
    for (int i = 0; i < 4; i++) send_byte(8'hFF);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_early: got %b want 0", done); end
    tick();
    n_checks++; if ({done, busy, full_err} !== 3'b100) begin n_fail++; $display("FAIL basic_end_flags: got %b want 100", {done, busy, full_err}); end
    n_checks++; if (word_count !== 6'd2) begin n_fail++; $display("FAIL basic_count: got %0d want 2", word_count); end
    n_checks++; if (wr_addr !== 32'd1) begin n_fail++; $display("FAIL basic_addr_hold: got %h want 1", wr_addr); end
    n_checks++; if (wq_data.size() !== 2) begin n_fail++; $display("FAIL basic_nwrites: got %0d want 2", wq_data.size()); end
    n_checks++; if ({wq_addr[0], wq_data[0]} !== {32'd0, 32'h0022_1820}) begin n_fail++; $display("FAIL basic_w0: got %h/%h want 0/00221820", wq_addr[0], wq_data[0]); end
    n_checks++; if ({wq_addr[1], wq_data[1]} !== {32'd1, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL basic_w1: got %h/%h want 1/ffffffff", wq_addr[1], wq_data[1]); end
    // Done state ignores further bytes.
    for (int i = 0; i < 4; i++) send_byte(8'h42);
    tick();
    n_checks++; if (wq_data.size() !== 2) begin n_fail++; $display("FAIL done_ignores_rx: got %0d writes want 2", wq_data.size()); end
  endtask

  task automatic test_back_to_back();
    int c4, c8;
    clear_log();
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      send_byte(8'(i + 1));
      if (i == 3) c4 = cyc;
      if (i == 7) c8 = cyc;
    end
    tick(); tick();
    n_checks++; if (wq_data.size() !== 2) begin n_fail++; $display("FAIL b2b_nwrites: got %0d want 2", wq_data.size()); end
    n_checks++; if (wq_cyc[0] !== c4) begin n_fail++; $display("FAIL b2b_lat0: got cycle %0d want %0d", wq_cyc[0], c4); end
    n_checks++; if (wq_cyc[1] !== c8) begin n_fail++; $display("FAIL b2b_lat1: got cycle %0d want %0d", wq_cyc[1], c8); end
    n_checks++; if ({wq_addr[0], wq_data[0]} !== {32'd0, 32'h0102_0304}) begin n_fail++; $display("FAIL b2b_w0: got %h/%h want 0/01020304", wq_addr[0], wq_data[0]); end
    n_checks++; if ({wq_addr[1], wq_data[1]} !== {32'd1, 32'h0506_0708}) begin n_fail++; $display("FAIL b2b_w1: got %h/%h want 1/05060708", wq_addr[1], wq_data[1]); end
    n_checks++; if ({busy, word_count} !== {1'b1, 6'd2}) begin n_fail++; $display("FAIL b2b_state: got busy=%b count=%0d want 1/2", busy, word_count); end
  endtask

  task automatic test_restart();
    clear_log();
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i));
    start    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h99;
    tick();
    start    = 1'b0;
    rx_valid = 1'b0;
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    tick(); tick();
    n_checks++; if (wq_data.size() !== 2) begin n_fail++; $display("FAIL restart_nwrites: got %0d want 2", wq_data.size()); end
    n_checks++; if ({wq_addr[0], wq_data[0]} !== {32'd0, 32'h1011_1213}) begin n_fail++; $display("FAIL restart_w0: got %h/%h want 0/10111213", wq_addr[0], wq_data[0]); end
    n_checks++; if ({wq_addr[1], wq_data[1]} !== {32'd0, 32'hAABB_CCDD}) begin n_fail++; $display("FAIL restart_w1: got %h/%h want 0/aabbccdd", wq_addr[1], wq_data[1]); end
    n_checks++; if (word_count !== 6'd1) begin n_fail++; $display("FAIL restart_count: got %0d want 1", word_count); end
  endtask

  task automatic test_fill();
    int bad = 0;
    clear_log();
    pulse_start();
    for (int w = 0; w < 32; w++) begin
      send_byte(8'(w)); send_byte(8'h5A); send_byte(8'hA5); send_byte(8'h3C);
    end
    tick(); tick();
    n_checks++; if (wq_data.size() !== 32) begin n_fail++; $display("FAIL fill_nwrites: got %0d want 32", wq_data.size()); end
    for (int w = 0; w < 32; w++) begin
      n_checks++;
      if ({wq_addr[w], wq_data[w]} !== {32'(w), 8'(w), 24'h5AA53C}) begin
        n_fail++;
        $display("FAIL fill_w%0d: got %h/%h want %h/%h", w, wq_addr[w], wq_data[w], 32'(w), {8'(w), 24'h5AA53C});
      end
    end
    n_checks++; if ({done, busy, full_err} !== 3'b101) begin n_fail++; $display("FAIL fill_flags: got %b want 101", {done, busy, full_err}); end
    n_checks++; if (word_count !== 6'd32) begin n_fail++; $display("FAIL fill_count: got %0d want 32", word_count); end
    n_checks++; if (wr_addr !== 32'd31) begin n_fail++; $display("FAIL fill_addr_hold: got %h want 31", wr_addr); end
    for (int i = 0; i < 8; i++) send_byte(8'h77);
    tick();
    n_checks++; if ({wq_data.size(), done, full_err} !== {32'd32, 2'b11}) begin n_fail++; $display("FAIL fill_after: got n=%0d done=%b err=%b want 32/1/1", wq_data.size(), done, full_err); end
  endtask

  task automatic test_halt_at_last();
    clear_log();
    pulse_start();
    n_checks++; if ({busy, full_err} !== 2'b10) begin n_fail++; $display("FAIL last_start_clears: got %b want 10", {busy, full_err}); end
    for (int w = 0; w < 31; w++) begin
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'(w));
    end
    for (int i = 0; i < 4; i++) send_byte(8'hFF);
    tick(); tick();
    n_checks++; if ({done, full_err} !== 2'b10) begin n_fail++; $display("FAIL last_halt_priority: got done=%b err=%b want 1/0", done, full_err); end
    n_checks++; if ({word_count, wr_addr} !== {6'd32, 32'd31}) begin n_fail++; $display("FAIL last_count_addr: got %0d/%h want 32/31", word_count, wr_addr); end
  endtask

  task automatic test_reset_mid_word();
    clear_log();
    pulse_start();
    send_byte(8'h12);
    send_byte(8'h34);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_busy: got %b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({wr_instruction, data_instruction, wr_addr} !== 65'h0) begin n_fail++; $display("FAIL midrst_async_port: got %b/%h/%h want 0", wr_instruction, data_instruction, wr_addr); end
    n_checks++; if ({busy, done, full_err, word_count} !== 9'h0) begin n_fail++; $display("FAIL midrst_async_flags: got %b/%b/%b/%0d want 0", busy, done, full_err, word_count); end
    #2 rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) send_byte(8'h56);
    tick();
    n_checks++; if ({wq_data.size(), busy} !== {32'd0, 1'b0}) begin n_fail++; $display("FAIL midrst_idle_rx: got n=%0d busy=%b want 0/0", wq_data.size(), busy); end
  endtask

  task automatic test_little_endian();
    for (int i = 0; i < 4; i++) begin
      rx_valid_le = 1'b1; rx_data_le = 8'h60 + 8'(i); tick();
    end
    rx_valid_le = 1'b0;
    tick();
    n_checks++; if (le_writes !== 0) begin n_fail++; $display("FAIL le_idle_rx: got %0d writes want 0", le_writes); end
    start_le = 1'b1; tick(); start_le = 1'b0;
    rx_valid_le = 1'b1; rx_data_le = 8'h11; tick();
    rx_data_le = 8'h22; tick();
    rx_data_le = 8'h33; tick();
    rx_data_le = 8'h44; tick();
    rx_valid_le = 1'b0;
    n_checks++; if ({wr_instruction_le, wr_addr_le} !== {1'b1, 32'd0}) begin n_fail++; $display("FAIL le_pulse: got %b/%h want 1/0", wr_instruction_le, wr_addr_le); end
    n_checks++; if (data_instruction_le !== 32'h4433_2211) begin n_fail++; $display("FAIL le_data: got %h want 44332211", data_instruction_le); end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    start_le = 1'b0; rx_valid_le = 1'b0; rx_data_le = 8'h00;
    repeat (2) tick();
    test_reset();
    rst = 1'b0;
    tick();
    // Bytes in IDLE must not write.
    for (int i = 0; i < 4; i++) send_byte(8'h33);
    tick();
    n_checks++; if (wq_data.size() !== 0) begin n_fail++; $display("FAIL idle_rx: got %0d writes want 0", wq_data.size()); end
    test_basic();
    test_back_to_back();
    test_restart();
    test_fill();
    test_halt_at_last();
    test_reset_mid_word();
    test_little_endian();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
